// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } sub_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: d = x - y - bi, bo = borrow out.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// File: rtl/serial_8bit_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock, with valid/ready
// handshakes on both the operand and result sides.
module serial_8bit_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  sub_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             d_bit;
  logic             bo_bit;

  full_subtractor_bit u_bit (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (borrow),
    .d  (d_bit),
    .bo (bo_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      borrow    <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      diff      <= '0;
      bout      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr     <= a;
            b_sr     <= b;
            borrow   <= bin;
            cnt      <= '0;
            state    <= CALC;
            in_ready <= 1'b0;
          end
        end
        CALC: begin
          // Result bits enter at the MSB so bit 0 lands in diff[0] after WIDTH shifts.
          diff   <= {d_bit, diff[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= bo_bit;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            bout      <= bo_bit;
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_8bit_subtractor.sv
// Directed and swept checks of serial_8bit_subtractor against hand-computed results.
module tb_serial_8bit_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_8bit_subtractor #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: accept, wait for result, hold under backpressure, release.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                        input int hold, input bit noise);
    logic [8:0] full;
    int         cyc;
    full = {1'b0, ta} - {1'b0, tb_v} - 9'(tbin);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a        = ta;
    b        = tb_v;
    bin      = tbin;
    in_valid = 1'b1;
    tick();
    in_valid = noise;
    if (noise) begin
      a = 8'hAA;
      b = 8'h55;
    end
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    check("latency", 32'(cyc), 32'd8);
    check("diff", 32'(diff), 32'(full[7:0]));
    check("bout", 32'(bout), 32'(full[8]));
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      check("in_ready_done", 32'(in_ready), 32'd0);
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_diff", 32'(diff), 32'(full[7:0]));
      check("hold_bout", 32'(bout), 32'(full[8]));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("released_valid", 32'(out_valid), 32'd0);
    check("released_ready", 32'(in_ready), 32'd1);
    check("released_diff", 32'(diff), 32'(full[7:0]));
  endtask

  initial begin
    bit seen_valid;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);

    run_op(8'h05, 8'h03, 1'b0, 0, 1'b0);
    check("v1_diff", 32'(diff), 32'h02);
    run_op(8'h00, 8'h01, 1'b0, 1, 1'b0);
    check("v2_diff", 32'(diff), 32'hFF);
    check("v2_bout", 32'(bout), 32'd1);
    run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    check("v3_diff", 32'(diff), 32'hFF);
    check("v3_bout", 32'(bout), 32'd1);
    run_op(8'h80, 8'h7F, 1'b1, 2, 1'b0);
    check("v4_diff", 32'(diff), 32'h00);
    check("v4_bout", 32'(bout), 32'd0);

    // Backpressure with a competing operand held on the inputs.
    run_op(8'h10, 8'h01, 1'b0, 5, 1'b1);
    check("bp_diff", 32'(diff), 32'h0F);
    check("bp_bout", 32'(bout), 32'd0);

    // Reset while bit 4 is being processed.
    a        = 8'h33;
    b        = 8'h11;
    bin      = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_diff", 32'(diff), 32'd0);
    check("mid_rst_bout", 32'(bout), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen_valid = 1'b1;
    end
    check("mid_rst_no_valid", 32'(seen_valid), 32'd0);
    run_op(8'h33, 8'h11, 1'b0, 0, 1'b0);
    check("after_rst_diff", 32'(diff), 32'h22);

    for (int i = 0; i < 1000; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
